// File: rtl/div_iter.sv
// Iterative 32-bit DIV/DIVU unit: restoring shift-subtract, 32 cycles, result to HI/LO.
// Optional DIV_FASTPATH_EN: skip iteration when |dividend| < |divisor|.
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_t;

  state_t      state, nextState;
  logic [4:0]  cnt;
  logic [64:0] work;
  logic [31:0] dvsr;
  logic [31:0] dvnd;
  logic        negQuot, negRem, divZero;

  logic        accept;
  logic [31:0] magA, magB;
  logic [64:0] shifted, stepWork;
  logic [31:0] quotMag, remMag, finalQuot, finalRem;

  assign accept = (state == IDLE) && start && !annul;
  assign magA   = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
  assign magB   = (signed_div && opdata2[31]) ? -opdata2 : opdata2;

  // work = {partial remainder (33b), dividend bits shifting into quotient (32b)}
  always_comb begin
    shifted  = {work[63:0], 1'b0};
    stepWork = shifted;
    if (shifted[64:32] >= {1'b0, dvsr})
      stepWork = {shifted[64:32] - {1'b0, dvsr}, shifted[31:1], 1'b1};
    quotMag   = stepWork[31:0];
    remMag    = stepWork[63:32];
    finalQuot = negQuot ? -quotMag : quotMag;
    finalRem  = negRem ? -remMag : remMag;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (opdata2 == '0)
            nextState = ZERO;
`ifdef DIV_FASTPATH_EN
          else if (magA < magB)
            nextState = ZERO;
`endif
          else
            nextState = ON;
        end
      end
      ZERO:    nextState = END;
      ON:      if (cnt == 5'd31) nextState = END;
      END:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (annul)
      nextState = IDLE;
  end

  assign ready = (state == END) && !annul;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      work    <= '0;
      dvsr    <= '0;
      dvnd    <= '0;
      negQuot <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      result  <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        cnt     <= '0;
        work    <= {33'b0, magA};
        dvsr    <= magB;
        dvnd    <= opdata1;
        negQuot <= signed_div && (opdata1[31] ^ opdata2[31]);
        negRem  <= signed_div && opdata1[31];
        divZero <= (opdata2 == '0);
      end else if (state == ON && !annul) begin
        work <= stepWork;
        cnt  <= cnt + 5'd1;
        if (cnt == 5'd31)
          result <= {finalRem, finalQuot};
      end else if (state == ZERO && !annul) begin
        // Fast-path quotient is 0 and remainder is the untouched signed dividend
        result <= divZero ? 64'h0 : {dvnd, 32'h0};
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed and random divides against an arithmetic model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1, opdata2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] lastRes;

  div_iter dut (
    .clk(clk), .rst(rst), .signed_div(signed_div), .opdata1(opdata1),
    .opdata2(opdata2), .start(start), .annul(annul), .result(result), .ready(ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    logic [31:0] qq, rr;
    if (b == 0) return 64'h0;
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    qq = q[31:0];
    rr = r[31:0];
    return {rr, qq};
  endfunction

  function automatic int refLat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint ma, mb;
    if (b == 0) return 2;
    ma = sgn ? longint'($signed(a)) : longint'(a);
    mb = sgn ? longint'($signed(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef DIV_FASTPATH_EN
    if (ma < mb) return 2;
`endif
    return 33;
  endfunction

  // Issue one divide with start held; operands scrambled right after the accept edge.
  task automatic doDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output int lat, output logic [63:0] res);
    @(negedge clk);
    signed_div = sgn; opdata1 = a; opdata2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    opdata1 = $urandom; opdata2 = $urandom; signed_div = ~sgn;
    lat = 0;
    res = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (ready) begin lat = k; res = result; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
    #2;
    compared++;
    if (result !== 64'h0 || ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: result=%h ready=%b, required result=0 ready=0", result, ready);
    end
    @(negedge clk);
    rst = 1'b0;
    lastRes = 64'h0;
  endtask

  task automatic test_divide;
    logic [31:0] as[$], bs[$];
    logic        ss[$];
    int lat;
    logic [63:0] res, exp;
    as = '{32'd100, 32'hFFFFFFF9, 32'h80000000, 32'd5, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFF9};
    bs = '{32'd7,   32'd2,        32'hFFFFFFFF, 32'd0, 32'd10, 32'd1,       32'hFFFFFFFF, 32'hFFFFFFFE, 32'd9, 32'hFFFFFFFE};
    ss = '{1'b0,    1'b1,         1'b1,         1'b0,  1'b0,  1'b0,         1'b1,         1'b1,         1'b1,  1'b1};
    for (int i = 0; i < 16; i++) begin
      as.push_back($urandom);
      case ($urandom_range(0, 3))
        0:       bs.push_back(32'd0);
        1:       bs.push_back($urandom_range(1, 300));
        default: bs.push_back($urandom);
      endcase
      ss.push_back(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < as.size(); i++) begin
      exp = refDiv(as[i], bs[i], ss[i]);
      doDiv(as[i], bs[i], ss[i], lat, res);
      compared++;
      if (lat !== refLat(as[i], bs[i], ss[i])) begin
        mismatched++;
        $display("FAIL latency[%0d] %h/%h s=%b: got %0d, required %0d", i, as[i], bs[i], ss[i], lat, refLat(as[i], bs[i], ss[i]));
      end
      compared++;
      if (res !== exp) begin
        mismatched++;
        $display("FAIL result[%0d] %h/%h s=%b: got %h, required %h", i, as[i], bs[i], ss[i], res, exp);
      end
      @(negedge clk);
      compared++;
      if (ready !== 1'b0 || result !== exp) begin
        mismatched++;
        $display("FAIL hold[%0d]: ready=%b result=%h, required ready=0 result=%h", i, ready, result, exp);
      end
      lastRes = exp;
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [63:0] exp;
    lat = 0;
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd33; start = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ready) break;
    end
    // New operands presented during END; the IDLE cycle after it is the accept
    signed_div = 1'b1; opdata1 = 32'hFFFFFC18; opdata2 = 32'd7;
    exp = refDiv(32'hFFFFFC18, 32'd7, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    opdata1 = $urandom; opdata2 = $urandom;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (ready) begin lat = k; break; end
    end
    compared++;
    if (lat !== 33 || result !== exp) begin
      mismatched++;
      $display("FAIL back_to_back: lat=%0d result=%h, required lat=33 result=%h", lat, result, exp);
    end
    start = 1'b0;
    lastRes = exp;
  endtask

  task automatic test_annul;
    int lat, seen;
    seen = 0; lat = 0;
    @(negedge clk);
    signed_div = 1'b0; opdata1 = $urandom; opdata2 = 32'd3; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    annul = 1'b1;
    @(negedge clk);
    if (ready) seen++;
    compared++;
    if (seen !== 0 || result !== lastRes) begin
      mismatched++;
      $display("FAIL annul_abort: ready_pulses=%0d result=%h, required 0 pulses result=%h", seen, result, lastRes);
    end
    annul = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (ready) begin lat = k; break; end
    end
    start = 1'b0;
    compared++;
    if (lat !== 33 || result !== {32'd2, 32'd14}) begin
      mismatched++;
      $display("FAIL annul_restart: lat=%0d result=%h, required lat=33 result=%h", lat, result, {32'd2, 32'd14});
    end
    lastRes = {32'd2, 32'd14};
    // annul outranks start in IDLE
    @(negedge clk);
    start = 1'b1; annul = 1'b1; opdata1 = 32'd9; opdata2 = 32'd0;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    compared++;
    if (seen !== 0 || result !== lastRes) begin
      mismatched++;
      $display("FAIL annul_priority: ready_pulses=%0d result=%h, required 0 pulses result=%h", seen, result, lastRes);
    end
  endtask

  task automatic test_reset_midop;
    int lat, seen;
    logic [63:0] res;
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd12345; opdata2 = 32'd11; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if (result !== 64'h0 || ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_midop: result=%h ready=%b, required result=0 ready=0", result, ready);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL reset_no_ghost: ready_pulses=%0d, required 0", seen);
    end
    doDiv(32'd3, 32'd10, 1'b0, lat, res);
    compared++;
    if (lat !== refLat(32'd3, 32'd10, 1'b0) || res !== {32'd3, 32'd0}) begin
      mismatched++;
      $display("FAIL small_dividend: lat=%0d result=%h, required lat=%0d result=%h", lat, res, refLat(32'd3, 32'd10, 1'b0), {32'd3, 32'd0});
    end
  endtask

  initial begin
    test_reset;
    test_divide;
    test_back_to_back;
    test_annul;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
